quad_pe_seq: RTL

QUAD_PE_SEQ -- requirements
Module: quad_pe_seq

---
 rtl/quad_pe_pkg.sv | 17 +
 rtl/ofm_out_slot.sv | 24 ++
 rtl/quad_pe_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/quad_pe_pkg.sv
// Shared widths and FSM state type for the quad-PE sequencer.
package quad_pe_pkg;
    localparam int ADDR_W    = 10;
    localparam int LANE_W    = 8;
    localparam int LANES     = 4;
    localparam int STEP_W    = 8;
    localparam int OFM_CNT_W = 8;
    localparam int DATA_W    = LANE_W * LANES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_WAIT_OUT,
        S_DONE
    } state_t;
endpackage

// File: rtl/ofm_out_slot.sv
// Single-entry valid/ready holding register for one OFM result.
module ofm_out_slot
    import quad_pe_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [LANE_W-1:0] load_data,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/quad_pe_seq.sv
// Sequences operand-buffer reads into a 4-lane PE and streams one 8-bit result per OFM.
module quad_pe_seq
    import quad_pe_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic [STEP_W-1:0]    cfg_num_steps,
    input  logic [OFM_CNT_W-1:0] cfg_num_ofm,
    input  logic                 cfg_mul_en,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    rd_ifm_data,
    input  logic [DATA_W-1:0]    rd_wgt_data,
    output logic [DATA_W-1:0]    pe_ifm,
    output logic [DATA_W-1:0]    pe_wgt,
    output logic                 pe_mul_en,
    output logic                 pe_reset,
    output logic                 pe_finish,
    input  logic [LANE_W-1:0]    pe_ofm,
    input  logic                 pe_valid,
    output logic [LANE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);
    state_t               state;
    logic [STEP_W-1:0]    num_steps;
    logic [STEP_W-1:0]    step_cnt;
    logic [OFM_CNT_W-1:0] ofm_left;
    logic                 slot_load;
    logic                 last_beat;

    // Operand data returns one cycle after the read, so it feeds the PE directly.
    assign pe_ifm    = rd_ifm_data;
    assign pe_wgt    = rd_wgt_data;
    assign slot_load = (state == S_DRAIN) && pe_valid;
    assign last_beat = (step_cnt == num_steps - STEP_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            pe_reset  <= 1'b0;
            pe_finish <= 1'b0;
            pe_mul_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            num_steps <= '0;
            step_cnt  <= '0;
            ofm_left  <= '0;
        end else begin
            pe_reset  <= 1'b0;
            pe_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr   <= cfg_base_addr;
                        num_steps <= (cfg_num_steps == '0) ? STEP_W'(1) : cfg_num_steps;
                        ofm_left  <= cfg_num_ofm;
                        pe_mul_en <= cfg_mul_en;
                        busy      <= 1'b1;
                        if (cfg_num_ofm == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_WAIT_OUT;
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (ofm_left != '0 && (!out_valid || out_ready)) begin
                        state    <= S_STREAM;
                        rd_en    <= 1'b1;
                        step_cnt <= '0;
                    end else if (ofm_left == '0 && !out_valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    // Strobes are registered here so they land in the data cycle of each beat.
                    rd_addr   <= rd_addr + ADDR_W'(1);
                    step_cnt  <= step_cnt + STEP_W'(1);
                    pe_reset  <= (step_cnt == '0);
                    pe_finish <= last_beat;
                    if (last_beat) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pe_valid) begin
                        ofm_left <= ofm_left - OFM_CNT_W'(1);
                        state    <= S_WAIT_OUT;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ofm_out_slot u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (slot_load),
        .load_data (pe_ofm),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );
endmodule
